// File: rtl/rv_stage_fifo_pkg.sv
// Shared types for the elastic stage buffer: the stage latch payload
// layout, its width, the buffered-entry record and the hazard match rule.
package rv_stage_fifo_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          instr;
        logic [31:0]          rs1_val;
        logic [31:0]          rs2_val;
        logic [31:0]          imm;
        logic [REG_IDX_W-1:0] rd;
        logic                 load_regfile;
    } stage_regs;

    localparam int unsigned STAGE_REGS_W = $bits(stage_regs);

    // Width is tied to the default payload; parametrised buffers keep
    // their fields in separate arrays instead.
    typedef struct packed {
        logic                    valid;
        logic                    ld_reg;
        logic [REG_IDX_W-1:0]    rd;
        logic [STAGE_REGS_W-1:0] data;
    } stage_fifo_entry_t;

    // x0 is hard-wired to zero, so it never creates a RAW dependency.
    function automatic logic rd_matches(input logic [REG_IDX_W-1:0] rd,
                                        input logic [REG_IDX_W-1:0] rs);
        return (rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/rv_stage_fifo_hazard_cam.sv
// RAW-hazard lookup: flags any valid, register-writing entry whose
// destination matches one of the two queried source registers.
module rv_stage_fifo_hazard_cam
    import rv_stage_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic [DEPTH-1:0]           v,
    input  logic [DEPTH-1:0]           ld_reg,
    input  logic [REG_IDX_W*DEPTH-1:0] rd,
    input  logic [REG_IDX_W-1:0]       q_rs1,
    input  logic [REG_IDX_W-1:0]       q_rs2,
    output logic                       q_hit1,
    output logic                       q_hit2
);

    // OR-reduce the per-entry match for each query port.
    always_comb begin
        q_hit1 = 1'b0;
        q_hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (v[i] && ld_reg[i]) begin
                if (rd_matches(rd[i*REG_IDX_W +: REG_IDX_W], q_rs1)) q_hit1 = 1'b1;
                if (rd_matches(rd[i*REG_IDX_W +: REG_IDX_W], q_rs2)) q_hit2 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv_stage_fifo.sv
// Elastic buffer between two pipeline stages: DEPTH-entry circular FIFO
// with valid/ready handshake, synchronous flush and a RAW-hazard query
// over buffered register writers.
module rv_stage_fifo
    import rv_stage_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = STAGE_REGS_W,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_ld_reg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CNT_W-1:0]     count,
    input  logic [REG_IDX_W-1:0] q_rs1,
    input  logic [REG_IDX_W-1:0] q_rs2,
    output logic                 q_hit1,
    output logic                 q_hit2
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0]           data_q [DEPTH];
    logic [REG_IDX_W-1:0]       rd_q   [DEPTH];
    logic [DEPTH-1:0]           ld_q;
    logic [DEPTH-1:0]           v_q;
    logic [PTR_W-1:0]           head_ptr;
    logic [PTR_W-1:0]           tail_ptr;
    logic [CNT_W-1:0]           count_q;
    logic                       push;
    logic                       pop;
    logic [REG_IDX_W*DEPTH-1:0] rd_flat;

    // Explicit wrap so non-power-of-two depths index correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    // in_ready depends only on occupancy: a full buffer refuses a push
    // even when the head is leaving in the same cycle.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign out_data  = data_q[head_ptr];
    assign count     = count_q;

    // Storage, pointers and occupancy; reset clears everything, flush
    // only empties the buffer and leaves stale payloads behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
            v_q      <= '0;
            ld_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= '0;
            end
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
            v_q      <= '0;
        end else begin
            if (push) begin
                data_q[tail_ptr] <= in_data;
                rd_q[tail_ptr]   <= in_rd;
                ld_q[tail_ptr]   <= in_ld_reg;
                v_q[tail_ptr]    <= 1'b1;
                tail_ptr         <= ptr_inc(tail_ptr);
            end
            if (pop) begin
                v_q[head_ptr] <= 1'b0;
                head_ptr      <= ptr_inc(head_ptr);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Flatten per-entry destinations for the hazard lookup.
    always_comb begin
        rd_flat = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rd_flat[i*REG_IDX_W +: REG_IDX_W] = rd_q[i];
        end
    end

    rv_stage_fifo_hazard_cam #(
        .DEPTH (DEPTH)
    ) u_hazard_cam (
        .v      (v_q),
        .ld_reg (ld_q),
        .rd     (rd_flat),
        .q_rs1  (q_rs1),
        .q_rs2  (q_rs2),
        .q_hit1 (q_hit1),
        .q_hit2 (q_hit2)
    );

    a_no_x_payload : assert property (@(posedge clk) disable iff (!rst_n)
        in_valid |-> !$isunknown(in_data));

    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= FULL_CNT);

endmodule

// File: tb/tb_rv_stage_fifo.sv
// Directed bench for rv_stage_fifo: table of per-cycle vectors on a
// DEPTH=2 buffer, plus hand sequences for DEPTH=3 wrap and DEPTH=1.
module tb_rv_stage_fifo;

    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, in_ld_reg, out_ready;
    logic [7:0] in_data;
    logic [4:0] in_rd, q_rs1, q_rs2;

    logic       d2_ir, d2_ov, d2_h1, d2_h2;
    logic [7:0] d2_od;
    logic [1:0] d2_cnt;
    logic       d3_ir, d3_ov, d3_h1, d3_h2;
    logic [7:0] d3_od;
    logic [1:0] d3_cnt;
    logic       d1_ir, d1_ov, d1_h1, d1_h2;
    logic [7:0] d1_od;
    logic [0:0] d1_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rv_stage_fifo #(.WIDTH(8), .DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(d2_ir), .in_data(in_data), .in_rd(in_rd), .in_ld_reg(in_ld_reg),
        .out_valid(d2_ov), .out_ready(out_ready), .out_data(d2_od), .count(d2_cnt),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(d2_h1), .q_hit2(d2_h2));

    rv_stage_fifo #(.WIDTH(8), .DEPTH(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(d3_ir), .in_data(in_data), .in_rd(in_rd), .in_ld_reg(in_ld_reg),
        .out_valid(d3_ov), .out_ready(out_ready), .out_data(d3_od), .count(d3_cnt),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(d3_h1), .q_hit2(d3_h2));

    rv_stage_fifo #(.WIDTH(8), .DEPTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(d1_ir), .in_data(in_data), .in_rd(in_rd), .in_ld_reg(in_ld_reg),
        .out_valid(d1_ov), .out_ready(out_ready), .out_data(d1_od), .count(d1_cnt),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(d1_h1), .q_hit2(d1_h2));

    typedef struct {
        logic       rst_n, flush, iv;
        logic [7:0] d;
        logic [4:0] rd;
        logic       ld, ordy;
        logic [4:0] q1, q2;
        logic       chk, chk_od;
        logic       e_ir, e_ov;
        logic [7:0] e_od;
        logic [1:0] e_cnt;
        logic       e_h1, e_h2;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
        in_rd = '0; in_ld_reg = 1'b0; out_ready = 1'b1; q_rs1 = '0; q_rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        int nxt, got, mcnt, k;
        logic m_push, m_pop;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        in_rd = '0; in_ld_reg = 1'b0; out_ready = 1'b0; q_rs1 = '0; q_rs2 = '0;

        // rst_n flush iv  d      rd ld ordy q1 q2  chk od  ir ov od     cnt h1 h2
        vecs[0]  = '{0, 0, 1, 8'hAA, 0, 0, 0, 0, 0,  0, 0,  0, 0, 8'h00, 0, 0, 0};
        vecs[1]  = '{0, 0, 1, 8'hAA, 0, 0, 0, 0, 0,  1, 1,  1, 0, 8'h00, 0, 0, 0};
        vecs[2]  = '{1, 0, 1, 8'h11, 5, 1, 0, 5, 0,  1, 1,  1, 0, 8'h00, 0, 0, 0};
        vecs[3]  = '{1, 0, 1, 8'h22, 0, 1, 0, 5, 0,  1, 1,  1, 1, 8'h11, 1, 1, 0};
        vecs[4]  = '{1, 0, 1, 8'h33, 7, 0, 1, 5, 0,  1, 1,  0, 1, 8'h11, 2, 1, 0};
        vecs[5]  = '{1, 0, 1, 8'h33, 7, 0, 1, 5, 7,  1, 1,  1, 1, 8'h22, 1, 0, 0};
        vecs[6]  = '{1, 0, 0, 8'h00, 0, 0, 0, 5, 7,  1, 1,  1, 1, 8'h33, 1, 0, 0};
        vecs[7]  = '{1, 0, 1, 8'h44, 9, 1, 0, 9, 0,  1, 1,  1, 1, 8'h33, 1, 0, 0};
        vecs[8]  = '{1, 1, 1, 8'h55, 3, 1, 1, 9, 3,  1, 1,  0, 1, 8'h33, 2, 1, 0};
        vecs[9]  = '{1, 0, 0, 8'h00, 0, 0, 1, 9, 3,  1, 0,  1, 0, 8'h00, 0, 0, 0};
        vecs[10] = '{1, 0, 1, 8'h66, 0, 0, 0, 0, 0,  1, 0,  1, 0, 8'h00, 0, 0, 0};
        vecs[11] = '{1, 0, 0, 8'h00, 0, 0, 1, 0, 0,  1, 1,  1, 1, 8'h66, 1, 0, 0};
        vecs[12] = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 0,  1, 0,  1, 0, 8'h00, 0, 0, 0};

        // DEPTH=2 table: inputs held for one cycle, outputs checked mid-cycle.
        for (int i = 0; i < 13; i++) begin
            rst_n = vecs[i].rst_n; flush = vecs[i].flush; in_valid = vecs[i].iv;
            in_data = vecs[i].d; in_rd = vecs[i].rd; in_ld_reg = vecs[i].ld;
            out_ready = vecs[i].ordy; q_rs1 = vecs[i].q1; q_rs2 = vecs[i].q2;
            @(negedge clk);
            if (vecs[i].chk) begin
                check($sformatf("v%0d_in_ready", i),  32'(d2_ir),  32'(vecs[i].e_ir));
                check($sformatf("v%0d_out_valid", i), 32'(d2_ov),  32'(vecs[i].e_ov));
                check($sformatf("v%0d_count", i),     32'(d2_cnt), 32'(vecs[i].e_cnt));
                check($sformatf("v%0d_q_hit1", i),    32'(d2_h1),  32'(vecs[i].e_h1));
                check($sformatf("v%0d_q_hit2", i),    32'(d2_h2),  32'(vecs[i].e_h2));
                if (vecs[i].chk_od)
                    check($sformatf("v%0d_out_data", i), 32'(d2_od), 32'(vecs[i].e_od));
            end
            @(posedge clk);
            #1;
        end

        // DEPTH=3: 7 payloads through a stalling consumer, exercising wrap.
        do_reset();
        @(negedge clk);
        check("d3_reset_count", 32'(d3_cnt), 32'd0);
        check("d3_reset_out_valid", 32'(d3_ov), 32'd0);
        @(posedge clk);
        #1;
        nxt = 1; got = 0; mcnt = 0;
        for (int cyc = 0; cyc < 60 && got < 7; cyc++) begin
            in_valid  = (nxt <= 7);
            in_data   = 8'(nxt);
            out_ready = (cyc >= 3) && (cyc % 3 != 0);
            @(negedge clk);
            check("d3_count", 32'(d3_cnt), 32'(mcnt));
            check("d3_in_ready", 32'(d3_ir), 32'(mcnt != 3));
            m_push = in_valid && (mcnt != 3);
            m_pop  = out_ready && (mcnt != 0);
            if (m_pop) begin
                check("d3_out_data", 32'(d3_od), 32'(got + 1));
                got++;
            end
            if (m_push) nxt++;
            mcnt = mcnt + int'(m_push) - int'(m_pop);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("d3_drained_all", 32'(got), 32'd7);

        // DEPTH=1: continuous offer and accept gives one transfer per 2 cycles.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1; k = 8'h41;
        for (int c = 0; c < 8; c++) begin
            in_data = 8'(k);
            @(negedge clk);
            check($sformatf("d1_in_ready_c%0d", c), 32'(d1_ir), 32'(c % 2 == 0));
            check($sformatf("d1_out_valid_c%0d", c), 32'(d1_ov), 32'(c % 2 == 1));
            if (c % 2 == 1) check($sformatf("d1_out_data_c%0d", c), 32'(d1_od), 32'(k - 1));
            else k++;
            @(posedge clk);
            #1;
            in_data = 8'(k);
        end
        in_valid = 1'b0; out_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
